// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
//
// Shared types and default constants for the tick-driven PWM stage.
//
//   pwm_state_t : FSM encoding for the PWM sequencer.
//                 IDLE     - counter parked at 0, output low, waiting for a
//                            tick with enable high.
//                 RUN      - counting ticks and producing PWM.
//                 STOPPING - enable dropped; the current period finishes
//                            before the block parks in IDLE.
//   PWM_WIDTH   : default width of the period counter and duty values.
//   PWM_PERIOD  : default number of ticks per PWM period.
// ---------------------------------------------------------------------------
package pwm_pkg;

  localparam int PWM_WIDTH  = 8;
  localparam int PWM_PERIOD = 256;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } pwm_state_t;

endpackage : pwm_pkg

// File: rtl/tick_edge_detect.sv
// ---------------------------------------------------------------------------
// tick_edge_detect
//
// Turns a slow level (the clock divider's square wave, already synchronous
// to clk) into a one-clk tick on each 0->1 transition. The level is only
// ever sampled as data; it is never used as a clock.
//
// Ports:
//   clk      in  1 : system clock, rising edge
//   reset    in  1 : asynchronous, active-high reset
//   level_in in  1 : divided-clock level
//   tick     out 1 : high for the cycle in which level_in is first seen high
//
// The history register resets to 1 so that a level which is already high
// when reset is released is not mistaken for a fresh rising edge.
// ---------------------------------------------------------------------------
module tick_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level_in,
  output logic tick
);

  logic level_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 1'b1;
    end else begin
      level_q <= level_in;
    end
  end

  assign tick = level_in & ~level_q;

endmodule : tick_edge_detect

// File: rtl/pwm_tick_generator.sv
// ---------------------------------------------------------------------------
// pwm_tick_generator
//
// Tick-driven PWM stage. Each rising edge of the divider output becomes a
// one-clk tick; ticks advance a period counter that wraps explicitly at
// PERIOD-1. The output is high while the counter is below the active duty.
//
// Parameters:
//   WIDTH  : counter / duty width (default PWM_WIDTH)
//   PERIOD : ticks per PWM period, 2 <= PERIOD <= 2**WIDTH
//            (default PWM_PERIOD)
//
// Ports:
//   clk          in  1     : system clock, rising edge
//   reset        in  1     : asynchronous, active-high reset
//   div_clk_in   in  1     : divided-clock level, synchronous to clk
//   enable       in  1     : run request
//   duty_in      in  WIDTH : new duty value (ticks high per period)
//   duty_load    in  1     : strobe, captures duty_in into the shadow
//   pwm_out      out 1     : registered PWM output
//   period_start out 1     : registered one-clk pulse at each period start
//   duty_pending out 1     : shadow duty loaded but not yet adopted
//
// Duty handling: duty_load writes a shadow register; the active duty only
// takes the shadow value at a period boundary (IDLE->RUN start or a RUN wrap).
// A load landing on the same edge as a boundary is not forwarded: the
// boundary adopts the old shadow and the new value waits one more period.
//
// The FSM state lives in state_q / state_d so it can be probed directly.
// ---------------------------------------------------------------------------
module pwm_tick_generator
  import pwm_pkg::*;
#(
  parameter int WIDTH  = PWM_WIDTH,
  parameter int PERIOD = PWM_PERIOD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_clk_in,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_load,
  output logic             pwm_out,
  output logic             period_start,
  output logic             duty_pending
);

  // Last count value of a period. When PERIOD == 2**WIDTH this is all ones,
  // otherwise the wrap happens well before the natural overflow.
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(PERIOD - 1);

  // -------------------------------------------------------------------------
  // Tick generation
  // -------------------------------------------------------------------------
  logic tick;

  tick_edge_detect u_tick_edge_detect (
    .clk      (clk),
    .reset    (reset),
    .level_in (div_clk_in),
    .tick     (tick)
  );

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  pwm_state_t       state_q;
  pwm_state_t       state_d;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] duty_shadow_q;
  logic [WIDTH-1:0] duty_active_q;
  logic [WIDTH-1:0] duty_active_d;
  logic             pwm_q;
  logic             pwm_d;
  logic             period_start_q;
  logic             pending_q;

  // boundary: this edge starts a new period (adopt shadow, pulse
  // period_start). Produced by the next-state logic.
  logic             boundary;

  // Shared counter helpers.
  logic             at_last;
  logic [WIDTH-1:0] cnt_inc;

  assign at_last = (cnt_q == CNT_LAST);
  assign cnt_inc = cnt_q + 1'b1;   // only used when cnt_q < CNT_LAST

  // -------------------------------------------------------------------------
  // FSM process 1: state register (plus counter, which moves with it)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM process 2: next state, next count, boundary detection
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    boundary = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tick && enable) begin
          state_d  = RUN;
          cnt_d    = '0;
          boundary = 1'b1;
        end
      end

      RUN: begin
        if (tick) begin
          if (at_last) begin
            cnt_d    = '0;
            boundary = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        // Dropping enable is noticed on any cycle; the PWM keeps running.
        if (!enable) begin
          state_d = STOPPING;
        end
      end

      STOPPING: begin
        if (enable) begin
          // Immediate return to RUN; a coincident tick is handled exactly
          // as it would be in RUN, including a normal wrap.
          state_d = RUN;
          if (tick) begin
            if (at_last) begin
              cnt_d    = '0;
              boundary = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end else if (tick) begin
          if (at_last) begin
            // Period finished: park without starting a new period.
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM process 3: output / datapath next values
  // -------------------------------------------------------------------------
  // The output is computed from the next state and next count so that
  // pwm_out changes on the same edge as the counter.
  always_comb begin
    duty_active_d = duty_active_q;
    pwm_d         = 1'b0;

    if (boundary) begin
      duty_active_d = duty_shadow_q;
    end

    // Unsigned compare: duty 0 never matches, duty >= PERIOD always does.
    pwm_d = (state_d != IDLE) && (cnt_d < duty_active_d);
  end

  // -------------------------------------------------------------------------
  // Duty registers and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_shadow_q  <= '0;
      duty_active_q  <= '0;
      pending_q      <= 1'b0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      duty_active_q  <= duty_active_d;
      pwm_q          <= pwm_d;
      period_start_q <= boundary;

      // A load always wins over a coincident boundary: the boundary has
      // already taken the old shadow, so the new one is still pending.
      if (duty_load) begin
        duty_shadow_q <= duty_in;
        pending_q     <= 1'b1;
      end else if (boundary) begin
        pending_q     <= 1'b0;
      end
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign duty_pending = pending_q;

endmodule : pwm_tick_generator

// File: tb/tb_pwm_tick_generator.sv
// ---------------------------------------------------------------------------
// tb_pwm_tick_generator
//
// Directed bench for pwm_tick_generator with WIDTH=3, PERIOD=4. The divider
// level is driven 1,1,1,0,0,0 (toggling every 3 clk), so one tick occurs
// every 6 clk, on the first cycle of each 6-cycle slot. Each vector row gives
// the hand-computed pwm_out / period_start / duty_pending after that tick.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge.
// ---------------------------------------------------------------------------
module tb_pwm_tick_generator;

  localparam int W = 3;
  localparam int P = 4;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         reset;
  logic         div_clk_in;
  logic         enable;
  logic [W-1:0] duty_in;
  logic         duty_load;
  logic         pwm_out;
  logic         period_start;
  logic         duty_pending;

  always #5 clk = ~clk;

  pwm_tick_generator #(
    .WIDTH  (W),
    .PERIOD (P)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .div_clk_in   (div_clk_in),
    .enable       (enable),
    .duty_in      (duty_in),
    .duty_load    (duty_load),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .duty_pending (duty_pending)
  );

  // -------------------------------------------------------------------------
  // Scoreboard counters and checker
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Vector table: expected outputs after each tick
  // -------------------------------------------------------------------------
  typedef struct {
    logic         pwm;       // pwm_out after the tick edge (held for the slot)
    logic         ps;        // period_start after the tick edge
    logic         pend;      // duty_pending after the tick edge
    int           load_idx;  // slot cycle carrying duty_load (-1 none)
    logic [W-1:0] load_val;
    int           blip_idx;  // slot cycle with enable forced low (-1 none)
    logic         en_after;  // enable level after the slot
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic pwm, input logic ps, input logic pend,
                         input int load_idx, input logic [W-1:0] load_val,
                         input int blip_idx, input logic en_after);
    vec_t v;
    v.pwm      = pwm;
    v.ps       = ps;
    v.pend     = pend;
    v.load_idx = load_idx;
    v.load_val = load_val;
    v.blip_idx = blip_idx;
    v.en_after = en_after;
    vecs.push_back(v);
  endtask

  // -------------------------------------------------------------------------
  // Driver: one 6-clk divider slot, tick on cycle 0
  // -------------------------------------------------------------------------
  task automatic run_tick(input vec_t v, input int num);
    string tag;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      div_clk_in = (i < 3);
      duty_load  = (i == v.load_idx);
      if (i == v.load_idx) duty_in = v.load_val;
      if (i == v.blip_idx) enable = 1'b0;
      else if (v.blip_idx >= 0 && i == v.blip_idx + 1) enable = 1'b1;
      @(posedge clk);
      #1;
      if (i == 0) begin
        tag = $sformatf("t%0d pwm", num);
        check_bit(tag, pwm_out, v.pwm);
        tag = $sformatf("t%0d period_start", num);
        check_bit(tag, period_start, v.ps);
        tag = $sformatf("t%0d pending", num);
        check_bit(tag, duty_pending, v.pend);
      end else if (i == 1) begin
        tag = $sformatf("t%0d period_start_one_clk", num);
        check_bit(tag, period_start, 1'b0);
      end else if (i == 5) begin
        tag = $sformatf("t%0d pwm_hold", num);
        check_bit(tag, pwm_out, v.pwm);
      end
    end
    enable = v.en_after;
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    reset      = 1'b1;
    div_clk_in = 1'b1;
    enable     = 1'b1;
    duty_in    = '0;
    duty_load  = 1'b0;

    // Reset held over a few edges with the divider level high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit("rst pwm", pwm_out, 1'b0);
    check_bit("rst period_start", period_start, 1'b0);
    check_bit("rst pending", duty_pending, 1'b0);
    reset = 1'b0;

    // Level already high at release: no tick, nothing starts even with
    // enable high. Load duty 1 while the level is low.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      div_clk_in = (i < 3);
      duty_load  = (i == 4);
      duty_in    = 3'd1;
      @(posedge clk);
      #1;
      check_bit($sformatf("rel%0d period_start", i), period_start, 1'b0);
      check_bit($sformatf("rel%0d pwm", i), pwm_out, 1'b0);
      if (i == 3) check_bit("rel pending_before_load", duty_pending, 1'b0);
      if (i == 4) check_bit("rel pending_after_load", duty_pending, 1'b1);
    end

    //       pwm ps pend load  val  blip en_after
    // duty 1: high 1 of 4 ticks, period_start on the first tick too
    add_vec(1, 1, 0, -1, 3'd0, -1, 1);  // t1  IDLE->RUN, cnt 0
    add_vec(0, 0, 0, -1, 3'd0, -1, 1);  // t2  cnt 1
    add_vec(0, 0, 0, -1, 3'd0, -1, 1);  // t3  cnt 2
    add_vec(0, 0, 0, -1, 3'd0, -1, 1);  // t4  cnt 3
    add_vec(1, 1, 0, -1, 3'd0, -1, 1);  // t5  wrap
    // load 3 at cnt 1: current period stays 1/4
    add_vec(0, 0, 0,  2, 3'd3, -1, 1);  // t6  cnt 1, load 3
    add_vec(0, 0, 1, -1, 3'd0, -1, 1);  // t7
    add_vec(0, 0, 1, -1, 3'd0, -1, 1);  // t8
    add_vec(1, 1, 0, -1, 3'd0, -1, 1);  // t9  adopt 3
    add_vec(1, 0, 0, -1, 3'd0, -1, 1);  // t10
    add_vec(1, 0, 0, -1, 3'd0, -1, 1);  // t11
    add_vec(0, 0, 0, -1, 3'd0, -1, 1);  // t12
    // load 2 on the wrap tick: this period still uses 3
    add_vec(1, 1, 1,  0, 3'd2, -1, 1);  // t13
    add_vec(1, 0, 1, -1, 3'd0, -1, 1);  // t14
    add_vec(1, 0, 1, -1, 3'd0, -1, 1);  // t15
    add_vec(0, 0, 1, -1, 3'd0, -1, 1);  // t16
    add_vec(1, 1, 0, -1, 3'd0, -1, 1);  // t17 adopt 2
    add_vec(1, 0, 0, -1, 3'd0, -1, 1);  // t18
    add_vec(0, 0, 0, -1, 3'd0, -1, 1);  // t19
    add_vec(0, 0, 0,  2, 3'd0, -1, 1);  // t20 load 0
    // duty 0: constant low, period_start still pulses
    add_vec(0, 1, 0, -1, 3'd0, -1, 1);  // t21
    add_vec(0, 0, 0, -1, 3'd0, -1, 1);  // t22
    add_vec(0, 0, 0, -1, 3'd0, -1, 1);  // t23
    add_vec(0, 0, 0,  2, 3'd7, -1, 1);  // t24 load 7
    // duty 7 (>= PERIOD): constant high
    add_vec(1, 1, 0, -1, 3'd0, -1, 1);  // t25
    add_vec(1, 0, 0, -1, 3'd0, -1, 1);  // t26
    add_vec(1, 0, 0, -1, 3'd0, -1, 1);  // t27
    add_vec(1, 0, 0, -1, 3'd0, -1, 1);  // t28
    add_vec(1, 1, 0,  2, 3'd1, -1, 1);  // t29 load 1
    // enable dropped at cnt 1: period completes, then IDLE
    add_vec(1, 0, 1, -1, 3'd0, -1, 0);  // t30 cnt 1, enable low after
    add_vec(1, 0, 1, -1, 3'd0, -1, 0);  // t31 STOPPING cnt 2
    add_vec(1, 0, 1, -1, 3'd0, -1, 0);  // t32 STOPPING cnt 3
    add_vec(0, 0, 1, -1, 3'd0, -1, 0);  // t33 wrap -> IDLE, no pulse
    add_vec(0, 0, 1, -1, 3'd0, -1, 1);  // t34 IDLE, enable low: no start
    add_vec(1, 1, 0, -1, 3'd0, -1, 1);  // t35 IDLE->RUN, adopt 1
    // one-cycle enable drop between ticks: back to RUN without a tick
    add_vec(0, 0, 0, -1, 3'd0,  2, 1);  // t36
    add_vec(0, 0, 0, -1, 3'd0, -1, 1);  // t37
    add_vec(0, 0, 0, -1, 3'd0, -1, 1);  // t38

    for (int k = 0; k < vecs.size(); k++) begin
      run_tick(vecs[k], k + 1);
    end

    // t39: wrap tick in RUN (duty 1) with a coincident load, then async
    // reset inside the same cycle, before the next clk edge.
    @(negedge clk);
    div_clk_in = 1'b1;
    duty_load  = 1'b1;
    duty_in    = 3'd3;
    @(posedge clk);
    #1;
    check_bit("t39 pwm", pwm_out, 1'b1);
    check_bit("t39 period_start", period_start, 1'b1);
    check_bit("t39 pending", duty_pending, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check_bit("async_rst pwm", pwm_out, 1'b0);
    check_bit("async_rst period_start", period_start, 1'b0);
    check_bit("async_rst pending", duty_pending, 1'b0);

    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      duty_load  = 1'b0;
      div_clk_in = (i < 3);
      if (i == 2) reset = 1'b0;
      @(posedge clk);
      #1;
      check_bit($sformatf("post_rst%0d pwm", i), pwm_out, 1'b0);
      check_bit($sformatf("post_rst%0d period_start", i), period_start, 1'b0);
    end

    // Restart from IDLE: the shadow was cleared, so duty is 0.
    vecs.delete();
    add_vec(0, 1, 0, -1, 3'd0, -1, 1);  // t40 IDLE->RUN, duty 0
    add_vec(0, 0, 0, -1, 3'd0, -1, 1);  // t41
    for (int k = 0; k < vecs.size(); k++) begin
      run_tick(vecs[k], k + 40);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Run-time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule : tb_pwm_tick_generator
